// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, payload width and the default bit period.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 234;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, or 8E1 with even parity when UART_RX_PARITY_EN is defined.
// Bits are sampled mid-bit from the synchronised line; results appear as one-cycle valid/frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_s;
  logic                 par_ok;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign par_ok = (parity_q == ^shift_q);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // A start bit that is high again at its midpoint was only a glitch.
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          parity_d  = rx_s;
          state_d   = STOP;
        end
      end
`endif
      // Leaving at mid stop bit lets a back-to-back start edge be caught half a bit later.
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s && par_ok) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = rx_s ? IDLE : BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
